// File: rtl/dekatron_pkg.sv
// Shared types and helpers for the dekatron step controller: FSM states,
// digit count and one-hot/binary conversion of cathode positions.
package dekatron_pkg;

   localparam int unsigned DIGITS = 10;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      PULSE,
      SETTLE,
      GAPWAIT
   } state_t;

   function automatic logic onehot_valid(logic [DIGITS-1:0] v);
      logic [3:0] ones;
      ones = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (v[i]) ones = ones + 4'd1;
      end
      return ones == 4'd1;
   endfunction

   // Returns 4'hF for anything that is not a single lit cathode.
   function automatic logic [3:0] onehot_to_bin(logic [DIGITS-1:0] v);
      logic [3:0] b;
      b = 4'hF;
      if (onehot_valid(v)) begin
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[i]) b = 4'(i);
         end
      end
      return b;
   endfunction

   function automatic logic [DIGITS-1:0] bin_to_onehot(logic [3:0] d);
      logic [DIGITS-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (d == 4'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [3:0] step_digit(logic [3:0] d, logic dec);
      logic [3:0] r;
      if (dec) r = (d == '0) ? 4'(DIGITS - 1) : d - 4'd1;
      else     r = (d == 4'(DIGITS - 1)) ? '0 : d + 4'd1;
      return r;
   endfunction

   function automatic logic step_wraps(logic [3:0] d, logic dec);
      return dec ? (d == '0) : (d == 4'(DIGITS - 1));
   endfunction

endpackage

// File: rtl/dekatron_step_ctrl_if.sv
// Request/response and tube-side signals of the dekatron step controller.
// master = requester/tube side, slave = controller.
interface dekatron_step_ctrl_if;
   import dekatron_pkg::*;

   logic              Request;
   logic              Dec;
   logic              Set;
   logic [3:0]        SetValue;
   logic [DIGITS-1:0] DekOut;
   logic              PulseRight;
   logic              PulseLeft;
   logic [DIGITS-1:0] DekIn;
   logic              Busy;
   logic              Done;
   logic              Carry;
   logic              Error;
   logic [3:0]        Value;

   modport master (
      output Request, Dec, Set, SetValue, DekOut,
      input  PulseRight, PulseLeft, DekIn, Busy, Done, Carry, Error, Value
   );

   modport slave (
      input  Request, Dec, Set, SetValue, DekOut,
      output PulseRight, PulseLeft, DekIn, Busy, Done, Carry, Error, Value
   );

endinterface

// File: rtl/dekatron_decoder.sv
// One-hot cathode vector to binary digit plus a single-cathode valid flag.
module dekatron_decoder
   import dekatron_pkg::*;
(
   input  logic [DIGITS-1:0] onehot,
   output logic [3:0]        bin,
   output logic              valid
);

   always_comb begin
      bin   = onehot_to_bin(onehot);
      valid = onehot_valid(onehot);
   end

endmodule

// File: rtl/dekatron_step_ctrl.sv
// Dekatron stepping/loading controller: issues step or load pulses, waits for
// the tube to confirm the position (with timeout), then reports Done/Carry.
module dekatron_step_ctrl
   import dekatron_pkg::*;
#(
   parameter int unsigned PULSE_WIDTH = 3,
   parameter int unsigned GAP         = 2,
   parameter int unsigned TIMEOUT     = 16
) (
   input logic                 hsClk,
   input logic                 Rst_n,
   dekatron_step_ctrl_if.slave bus
);

   state_t      state;
   logic [15:0] cnt;
   logic [3:0]  exp_pos;
   logic        wrap;
   logic        is_load;
   logic        timed_out;

   logic [3:0]  dek_bin;
   logic        dek_valid;

   dekatron_decoder u_decoder (
      .onehot (bus.DekOut),
      .bin    (dek_bin),
      .valid  (dek_valid)
   );

   always_ff @(posedge hsClk or negedge Rst_n) begin
      if (!Rst_n) begin
         state          <= IDLE;
         cnt            <= '0;
         exp_pos        <= '0;
         wrap           <= 1'b0;
         is_load        <= 1'b0;
         timed_out      <= 1'b0;
         bus.PulseRight <= 1'b0;
         bus.PulseLeft  <= 1'b0;
         bus.DekIn      <= '0;
         bus.Busy       <= 1'b0;
         bus.Done       <= 1'b0;
         bus.Carry      <= 1'b0;
         bus.Error      <= 1'b0;
         bus.Value      <= 4'hF;
      end else begin
         bus.Value <= dek_valid ? dek_bin : 4'hF;
         bus.Done  <= 1'b0;
         bus.Carry <= 1'b0;

         unique case (state)
            IDLE: begin
               // Set outranks Request; both are dropped while busy.
               if (bus.Set) begin
                  if (bus.SetValue < 4'(DIGITS)) begin
                     state     <= LOAD;
                     bus.DekIn <= bin_to_onehot(bus.SetValue);
                     exp_pos   <= bus.SetValue;
                     is_load   <= 1'b1;
                     wrap      <= 1'b0;
                     timed_out <= 1'b0;
                     cnt       <= '0;
                     bus.Busy  <= 1'b1;
                  end else begin
                     bus.Error <= 1'b1;
                  end
               end else if (bus.Request) begin
                  if (dek_valid) begin
                     state          <= PULSE;
                     bus.PulseRight <= ~bus.Dec;
                     bus.PulseLeft  <= bus.Dec;
                     exp_pos        <= step_digit(dek_bin, bus.Dec);
                     wrap           <= step_wraps(dek_bin, bus.Dec);
                     is_load        <= 1'b0;
                     timed_out      <= 1'b0;
                     cnt            <= '0;
                     bus.Busy       <= 1'b1;
                  end else begin
                     bus.Error <= 1'b1;
                  end
               end
            end

            LOAD, PULSE: begin
               if (cnt == 16'(PULSE_WIDTH - 1)) begin
                  state          <= SETTLE;
                  bus.PulseRight <= 1'b0;
                  bus.PulseLeft  <= 1'b0;
                  bus.DekIn      <= '0;
                  cnt            <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            SETTLE: begin
               if (dek_valid && dek_bin == exp_pos) begin
                  state <= GAPWAIT;
                  cnt   <= '0;
               end else if (cnt == 16'(TIMEOUT - 1)) begin
                  state     <= GAPWAIT;
                  bus.Error <= 1'b1;
                  timed_out <= 1'b1;
                  cnt       <= '0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            GAPWAIT: begin
               if (cnt == 16'(GAP - 1)) begin
                  state     <= IDLE;
                  bus.Busy  <= 1'b0;
                  bus.Done  <= 1'b1;
                  bus.Carry <= wrap & ~timed_out;
                  // Only a confirmed load proves the tube is healthy again.
                  if (is_load && !timed_out) bus.Error <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   a_drive_exclusive: assert property (@(posedge hsClk) disable iff (!Rst_n)
      $onehot0({bus.PulseRight, bus.PulseLeft, |bus.DekIn}));

   a_dekin_single: assert property (@(posedge hsClk) disable iff (!Rst_n)
      $onehot0(bus.DekIn));

endmodule
